// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard types: register address, per-register pending entry, widths.
package reg_scoreboard_pkg;

    localparam int unsigned SB_NREG   = 32;
    localparam int unsigned SB_ADDR_W = 5;
    localparam int unsigned SB_LAT_W  = 3;
    localparam int unsigned SB_CNT_W  = 6;

    typedef logic [SB_ADDR_W-1:0] creg_addr_t;

    // is_var marks a variable-latency producer; cnt is the forwarding countdown.
    typedef struct packed {
        logic                busy;
        logic                is_var;
        logic [SB_LAT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One register's pending entry: allocate, countdown, writeback clear, flush.
module reg_scoreboard_sb_entry
    import reg_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                wb_hit,
    input  logic                alloc,
    input  logic [SB_LAT_W-1:0] alloc_lat,
    output sb_entry_t           entry_q,
    output logic                busy_nxt
);

    sb_entry_t entry_d;

    // Lowest priority first so later assignments override.
    always_comb begin
        entry_d = entry_q;
        if (entry_q.busy && !entry_q.is_var && (entry_q.cnt != '0)) begin
            entry_d.cnt = entry_q.cnt - SB_LAT_W'(1);
        end
        if (alloc) begin
            entry_d.busy   = 1'b1;
            entry_d.is_var = (alloc_lat == '0);
            entry_d.cnt    = alloc_lat;
        end
        if (wb_hit) begin
            entry_d = '0;
        end
        if (flush) begin
            entry_d = '0;
        end
    end

    assign busy_nxt = entry_d.busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW/WAW issue gating and bypass-ready flags for 31 registers.
// Optional SCOREBOARD_WB_BYPASS_EN: a register under writeback this cycle counts as not busy.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NREG  = SB_NREG,
    parameter int unsigned LAT_W = SB_LAT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  creg_addr_t          src1,
    input  creg_addr_t          src2,
    input  logic                use1,
    input  logic                use2,
    input  creg_addr_t          dst,
    input  logic                dst_we,
    input  logic [LAT_W-1:0]    dst_lat,
    input  logic                wb_valid,
    input  creg_addr_t          wb_addr,
    output logic                fwd1,
    output logic                fwd2,
    output logic [SB_CNT_W-1:0] pending_cnt,
    output logic                idle
);

    logic [NREG-1:0] busy_v;
    logic [NREG-1:0] var_v;
    logic [NREG-1:0] cnt_nz_v;
    logic [NREG-1:0] busy_nxt_v;
    logic [NREG-1:0] wb_byp_v;
    logic [NREG-1:0] eff_busy_v;
    logic            accept;
    logic            blocked1;
    logic            blocked2;
    logic            waw;

    logic [SB_CNT_W-1:0] pending_cnt_d, pending_cnt_q;
    logic                flush_d, flush_q;

    assign busy_v[0]     = 1'b0;
    assign var_v[0]      = 1'b0;
    assign cnt_nz_v[0]   = 1'b0;
    assign busy_nxt_v[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        sb_entry_t entry;

        reg_scoreboard_sb_entry u_entry (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .wb_hit    (wb_valid && (wb_addr == SB_ADDR_W'(i))),
            .alloc     (accept && dst_we && (dst == SB_ADDR_W'(i))),
            .alloc_lat (SB_LAT_W'(dst_lat)),
            .entry_q   (entry),
            .busy_nxt  (busy_nxt_v[i])
        );

        assign busy_v[i]   = entry.busy;
        assign var_v[i]    = entry.is_var;
        assign cnt_nz_v[i] = (entry.cnt != '0);
    end

    // Writeback lookthrough mask for the hazard checks.
    always_comb begin
        wb_byp_v = '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid) begin
            wb_byp_v[wb_addr] = 1'b1;
        end
`endif
    end

    assign eff_busy_v = busy_v & ~wb_byp_v;

    always_comb begin
        blocked1    = use1 && eff_busy_v[src1] && (var_v[src1] || cnt_nz_v[src1]);
        blocked2    = use2 && eff_busy_v[src2] && (var_v[src2] || cnt_nz_v[src2]);
        fwd1        = use1 && eff_busy_v[src1] && !var_v[src1] && !cnt_nz_v[src1];
        fwd2        = use2 && eff_busy_v[src2] && !var_v[src2] && !cnt_nz_v[src2];
        waw         = dst_we && eff_busy_v[dst];
        issue_ready = !flush && !blocked1 && !blocked2 && !waw;
    end

    assign accept = issue_valid && issue_ready;

    // Busy count tracks the next-state vector so it lines up with the entries.
    always_comb begin
        pending_cnt_d = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            pending_cnt_d = pending_cnt_d + SB_CNT_W'(busy_nxt_v[i]);
        end
        flush_d = flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_cnt_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            pending_cnt_q <= pending_cnt_d;
            flush_q       <= flush_d;
        end
    end

    assign pending_cnt = pending_cnt_q;
    assign idle        = (pending_cnt_q == '0);

    // A stray writeback is only legitimate right after a flush dropped its entry.
    a_wb_busy: assert property (@(posedge clk) disable iff (reset)
        (wb_valid && (wb_addr != '0) && !flush_q) |-> busy_v[wb_addr])
        else $error("reg_scoreboard: writeback to non-busy register %0d", wb_addr);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [4:0] src1 = '0, src2 = '0, dst = '0, wb_addr = '0;
    logic       use1 = 1'b0, use2 = 1'b0, dst_we = 1'b0, wb_valid = 1'b0;
    logic [2:0] dst_lat = '0;
    logic       fwd1, fwd2, idle;
    logic [5:0] pending_cnt;

    int total = 0;
    int bad   = 0;

    reg_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .src1        (src1),
        .src2        (src2),
        .use1        (use1),
        .use2        (use2),
        .dst         (dst),
        .dst_we      (dst_we),
        .dst_lat     (dst_lat),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .fwd1        (fwd1),
        .fwd2        (fwd2),
        .pending_cnt (pending_cnt),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0; issue_valid = 1'b0; dst_we = 1'b0; dst = '0; dst_lat = '0;
        use1 = 1'b0; use2 = 1'b0; src1 = '0; src2 = '0; wb_valid = 1'b0; wb_addr = '0;
    endtask

    task automatic issue_dst(input logic [4:0] d, input logic [2:0] lat);
        clear_inputs();
        issue_valid = 1'b1; dst_we = 1'b1; dst = d; dst_lat = lat;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        use1 = 1'b1; src1 = 5'd5; use2 = 1'b1; src2 = 5'd7;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
        total++; if ({fwd1, fwd2} !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%b exp=00", {fwd1, fwd2}); end
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        clear_inputs();
    endtask

    task automatic test_fixed_lat();
        issue_dst(5'd5, 3'd2);
        issue_valid = 1'b1; use1 = 1'b1; src1 = 5'd5;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fix_stall0 got=%b exp=0", issue_ready); end
        total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL fix_pending got=%0d exp=1", pending_cnt); end
        step();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fix_stall1 got=%b exp=0", issue_ready); end
        step();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL fix_ready got=%b exp=1", issue_ready); end
        total++; if (fwd1 !== 1'b1) begin bad++; $display("FAIL fix_fwd1 got=%b exp=1", fwd1); end
        clear_inputs();
        wb_valid = 1'b1; wb_addr = 5'd5;
        step();
        clear_inputs();
        #1;
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL fix_wb_pending got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_lat1_both_src();
        issue_dst(5'd6, 3'd1);
        use1 = 1'b1; src1 = 5'd6; use2 = 1'b1; src2 = 5'd6;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL lat1_stall got=%b exp=0", issue_ready); end
        step();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL lat1_ready got=%b exp=1", issue_ready); end
        total++; if ({fwd1, fwd2} !== 2'b11) begin bad++; $display("FAIL lat1_fwd got=%b exp=11", {fwd1, fwd2}); end
        clear_inputs();
        wb_valid = 1'b1; wb_addr = 5'd6;
        step();
        clear_inputs();
        #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL lat1_idle got=%b exp=1", idle); end
    endtask

    task automatic test_var_lat();
        logic exp_wb_ready;
`ifdef SCOREBOARD_WB_BYPASS_EN
        exp_wb_ready = 1'b1;
`else
        exp_wb_ready = 1'b0;
`endif
        issue_dst(5'd7, 3'd0);
        issue_valid = 1'b1; use2 = 1'b1; src2 = 5'd7;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL var_stall0 got=%b exp=0", issue_ready); end
        total++; if (fwd2 !== 1'b0) begin bad++; $display("FAIL var_fwd2 got=%b exp=0", fwd2); end
        step(); step();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL var_stall2 got=%b exp=0", issue_ready); end
        wb_valid = 1'b1; wb_addr = 5'd7;
        #1;
        total++; if (issue_ready !== exp_wb_ready) begin bad++; $display("FAIL var_wb_cycle got=%b exp=%b", issue_ready, exp_wb_ready); end
        total++; if (fwd2 !== 1'b0) begin bad++; $display("FAIL var_wb_fwd2 got=%b exp=0", fwd2); end
        step();
        wb_valid = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL var_after_wb got=%b exp=1", issue_ready); end
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL var_pending got=%0d exp=0", pending_cnt); end
        clear_inputs();
    endtask

    task automatic test_waw();
        logic exp_wb_ready;
`ifdef SCOREBOARD_WB_BYPASS_EN
        exp_wb_ready = 1'b1;
`else
        exp_wb_ready = 1'b0;
`endif
        issue_dst(5'd9, 3'd0);
        issue_valid = 1'b1; dst_we = 1'b1; dst = 5'd9; dst_lat = 3'd1;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_stall0 got=%b exp=0", issue_ready); end
        step();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_stall1 got=%b exp=0", issue_ready); end
        issue_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd9;
        #1;
        total++; if (issue_ready !== exp_wb_ready) begin bad++; $display("FAIL waw_wb_cycle got=%b exp=%b", issue_ready, exp_wb_ready); end
        step();
        wb_valid = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL waw_after_wb got=%b exp=1", issue_ready); end
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL waw_pending got=%0d exp=0", pending_cnt); end
        clear_inputs();
    endtask

    task automatic test_r0();
        clear_inputs();
        issue_valid = 1'b1; dst_we = 1'b1; dst = 5'd0; dst_lat = 3'd1;
        use1 = 1'b1; src1 = 5'd0;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL r0_ready0 got=%b exp=1", issue_ready); end
        step();
        dst_we = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL r0_ready1 got=%b exp=1", issue_ready); end
        total++; if (fwd1 !== 1'b0) begin bad++; $display("FAIL r0_fwd1 got=%b exp=0", fwd1); end
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL r0_pending got=%0d exp=0", pending_cnt); end
        clear_inputs();
    endtask

    task automatic test_flush();
        issue_dst(5'd3, 3'd0);
        issue_dst(5'd4, 3'd0);
        issue_dst(5'd5, 3'd0);
        #1;
        total++; if (pending_cnt !== 6'd3) begin bad++; $display("FAIL flush_pre_pending got=%0d exp=3", pending_cnt); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL flush_pre_idle got=%b exp=0", idle); end
        flush = 1'b1;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
        step();
        flush = 1'b0;
        #1;
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL flush_pending got=%0d exp=0", pending_cnt); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL flush_idle got=%b exp=1", idle); end
        wb_valid = 1'b1; wb_addr = 5'd4;
        step();
        clear_inputs();
        use1 = 1'b1; src1 = 5'd4;
        #1;
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL flush_late_wb got=%0d exp=0", pending_cnt); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL flush_src_ready got=%b exp=1", issue_ready); end
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        issue_dst(5'd10, 3'd3);
        use1 = 1'b1; src1 = 5'd10;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL rstb_stall got=%b exp=0", issue_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rstb_ready got=%b exp=1", issue_ready); end
        total++; if ({fwd1, fwd2} !== 2'b00) begin bad++; $display("FAIL rstb_fwd got=%b exp=00", {fwd1, fwd2}); end
        total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL rstb_pending got=%0d exp=0", pending_cnt); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fixed_lat();
        test_lat1_both_src();
        test_var_lat();
        test_waw();
        test_r0();
        test_flush();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
